// File: rtl/pss_pkg.sv
// -----------------------------------------------------------------------------
// pss_pkg
// Shared types and helpers for the player-select screen generator.
//   - pss_state_e : controller states (IDLE, FILL, DONE)
//   - LFSR_TAPS_W*: default Fibonacci tap masks for common LFSR widths
//   - lfsr_next() : one Fibonacci step on a value up to 32 bits wide
// -----------------------------------------------------------------------------
package pss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } pss_state_e;

  // Tap masks for a left-shifting register whose feedback enters bit 0.
  localparam logic [31:0] LFSR_TAPS_W4  = 32'h0000_000C;
  localparam logic [31:0] LFSR_TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_W32 = 32'h8020_0003;

  // One LFSR step. 'width' bits are significant; upper bits come back zero.
  // The all-zero state is a lock-up state, so it is steered back to 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic [31:0] mask;
    logic [31:0] nxt;
    logic        fb;
    if (width >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    fb  = ^(state & taps & mask);
    nxt = ((state << 1) | {31'd0, fb}) & mask;
    if ((state & mask) == 32'd0) begin
      nxt = 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pss_lfsr.sv
// -----------------------------------------------------------------------------
// pss_lfsr
// Free-running Fibonacci LFSR; steps on every clock edge.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-low (loads the seed)
//   state out  current LFSR register value, W bits
// A zero seed is replaced by 1 so the register never starts locked up.
// -----------------------------------------------------------------------------
module pss_lfsr
  import pss_pkg::*;
#(
  parameter int            W    = 8,
  parameter logic [W-1:0]  TAPS = W'(8'hB8),
  parameter logic [W-1:0]  SEED = W'(8'h01)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] SEED_FIX = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] state_r;

  // LFSR register: advances every cycle regardless of controller state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= SEED_FIX;
    end else begin
      state_r <= W'(lfsr_next(32'(state_r), 32'(TAPS), W));
    end
  end

  assign state = state_r;

endmodule

// File: rtl/player_select_screens_gen.sv
// -----------------------------------------------------------------------------
// player_select_screens_gen
// Captures pseudo-random symbols into N_SCREENS slots, one per debounced
// rising edge of the player button, then reports completion.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-low
//   button  in   raw player button, asynchronous to clk
//   screens out  packed slots, slot i at [i*SYM_W +: SYM_W]
//   count   out  number of filled slots
//   done    out  high while all slots are filled (DONE state)
//   busy    out  high while filling (FILL state)
// Optional feature macro: PSS_NO_REPEAT_EN
//   When defined, a FILL press whose symbol equals the previous slot is held
//   pending and written on the first later cycle with a different symbol.
// -----------------------------------------------------------------------------
module player_select_screens_gen
  import pss_pkg::*;
#(
  parameter int                 N_SCREENS = 4,
  parameter int                 SYM_W     = 2,
  parameter int                 LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = LFSR_W'(8'hB8),
  parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(8'h01)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           button,
  output logic [N_SCREENS*SYM_W-1:0]     screens,
  output logic [$clog2(N_SCREENS+1)-1:0] count,
  output logic                           done,
  output logic                           busy
);

  localparam int CNT_W = $clog2(N_SCREENS+1);
  localparam int SCR_W = N_SCREENS*SYM_W;

  logic [LFSR_W-1:0] lfsr_s;
  logic [SYM_W-1:0]  sym_s;
  logic              lfsr_unused;

  pss_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_s)
  );

  assign sym_s       = lfsr_s[SYM_W-1:0];
  assign lfsr_unused = ^lfsr_s;

  // Button synchroniser / edge detector. seen_r marks that b1 holds a real
  // sample; armed_r is set once the button has been sampled low, so a button
  // held through reset release cannot create a press.
  logic b1_r, b2_r, b3_r, seen_r, armed_r;
  logic press_s;

  // Synchroniser chain plus arming flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b1_r    <= 1'b0;
      b2_r    <= 1'b0;
      b3_r    <= 1'b0;
      seen_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      b1_r   <= button;
      b2_r   <= b1_r;
      b3_r   <= b2_r;
      seen_r <= 1'b1;
      if (seen_r && !b1_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  assign press_s = b2_r & ~b3_r & armed_r;

  pss_state_e        state_r, state_n;
  logic [SCR_W-1:0]  screens_r, screens_n;
  logic [CNT_W-1:0]  count_r, count_n;
  logic              do_write_s;

`ifdef PSS_NO_REPEAT_EN
  logic              pending_r, pending_n;
  logic [SYM_W-1:0]  prev_sym_s;
`endif

  // Controller state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      screens_r <= '0;
      count_r   <= '0;
`ifdef PSS_NO_REPEAT_EN
      pending_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      screens_r <= screens_n;
      count_r   <= count_n;
`ifdef PSS_NO_REPEAT_EN
      pending_r <= pending_n;
`endif
    end
  end

  // Next-state logic: slot writes, count update and clearing press.
  always_comb begin
    state_n    = state_r;
    screens_n  = screens_r;
    count_n    = count_r;
    do_write_s = 1'b0;
`ifdef PSS_NO_REPEAT_EN
    pending_n  = pending_r;
    if (count_r != '0) begin
      prev_sym_s = screens_r[(int'(count_r)-1)*SYM_W +: SYM_W];
    end else begin
      prev_sym_s = '0;
    end
`endif
    case (state_r)
      IDLE: begin
        if (press_s) begin
          screens_n[0 +: SYM_W] = sym_s;
          count_n               = CNT_W'(1);
          state_n               = (N_SCREENS == 1) ? DONE : FILL;
        end else begin
          state_n = IDLE;
        end
      end
      FILL: begin
`ifdef PSS_NO_REPEAT_EN
        // A deferred write ignores further presses until it lands.
        if (pending_r) begin
          do_write_s = (sym_s != prev_sym_s);
        end else if (press_s) begin
          if ((SYM_W > 1) && (sym_s == prev_sym_s)) begin
            pending_n = 1'b1;
          end else begin
            do_write_s = 1'b1;
          end
        end else begin
          do_write_s = 1'b0;
        end
`else
        do_write_s = press_s;
`endif
        if (do_write_s) begin
          screens_n[int'(count_r)*SYM_W +: SYM_W] = sym_s;
          count_n = count_r + CNT_W'(1);
`ifdef PSS_NO_REPEAT_EN
          pending_n = 1'b0;
`endif
          if ((count_r + CNT_W'(1)) == CNT_W'(N_SCREENS)) begin
            state_n = DONE;
          end else begin
            state_n = FILL;
          end
        end else begin
          state_n = FILL;
        end
      end
      DONE: begin
        // The clearing press empties the screens without capturing.
        if (press_s) begin
          screens_n = '0;
          count_n   = '0;
          state_n   = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        screens_n = '0;
        count_n   = '0;
        state_n   = IDLE;
`ifdef PSS_NO_REPEAT_EN
        pending_n = 1'b0;
`endif
      end
    endcase
  end

  assign screens = screens_r;
  assign count   = count_r;
  assign done    = (state_r == DONE);
  assign busy    = (state_r == FILL);

endmodule

// File: tb/tb_player_select_screens_gen.sv
// -----------------------------------------------------------------------------
// tb_player_select_screens_gen
// Directed, table-driven bench for player_select_screens_gen. A bench-side
// LFSR model supplies the expected captured symbols.
// -----------------------------------------------------------------------------
module tb_player_select_screens_gen;

`ifdef PSS_NO_REPEAT_EN
  localparam int                N_SCREENS = 8;
  localparam int                SYM_W     = 3;
  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] TAPS      = 16'hB400;
  localparam int                MAX_WAIT  = 4;
`else
  localparam int                N_SCREENS = 4;
  localparam int                SYM_W     = 2;
  localparam int                LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] TAPS      = 8'hB8;
  localparam int                MAX_WAIT  = 0;
`endif
  localparam logic [LFSR_W-1:0] SEED  = LFSR_W'(1);
  localparam int                CNT_W = $clog2(N_SCREENS+1);

  logic                       clk;
  logic                       rst;
  logic                       button;
  logic [N_SCREENS*SYM_W-1:0] screens;
  logic [CNT_W-1:0]           count;
  logic                       done;
  logic                       busy;

  int n_checks = 0;
  int n_errors = 0;

  player_select_screens_gen #(
    .N_SCREENS (N_SCREENS),
    .SYM_W     (SYM_W),
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (TAPS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .button  (button),
    .screens (screens),
    .count   (count),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: mdl is the current value, mdl_prev the value before the
  // most recent edge (the symbol a write on that edge captures).
  logic [LFSR_W-1:0] mdl, mdl_prev;

  function automatic logic [LFSR_W-1:0] model_step(input logic [LFSR_W-1:0] s);
    logic fb;
    logic [LFSR_W-1:0] n;
    fb = 1'b0;
    for (int i = 0; i < LFSR_W; i++) begin
      if (TAPS[i]) fb = fb ^ s[i];
    end
    n = {s[LFSR_W-2:0], fb};
    if (n == '0) n = LFSR_W'(1);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl      <= SEED;
      mdl_prev <= SEED;
    end else begin
      mdl_prev <= mdl;
      mdl      <= model_step(mdl);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One press: button rises before a sampling edge; the write is due two
  // edges later (up to MAX_WAIT further edges when a repeat is deferred).
  task automatic press(input int exp_count, input bit exp_done, input bit exp_busy,
                       input bit capture, input bit release_btn, input string tag);
    int lat;
    logic [SYM_W-1:0] got_sym;
    @(negedge clk);
    button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lat = 0;
    while ((count !== CNT_W'(exp_count)) && (lat < MAX_WAIT)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_count"}, 64'(count), 64'(exp_count));
    chk({tag, "_done"},  64'(done),  64'(exp_done));
    chk({tag, "_busy"},  64'(busy),  64'(exp_busy));
    if (capture) begin
      got_sym = screens[(exp_count-1)*SYM_W +: SYM_W];
      chk({tag, "_slot"}, 64'(got_sym), 64'(mdl_prev[SYM_W-1:0]));
    end else begin
      chk({tag, "_clear"}, 64'(screens), 64'd0);
    end
    if (release_btn) begin
      @(negedge clk);
      button = 1'b0;
      repeat (3) @(posedge clk);
    end
  endtask

  typedef struct {
    int exp_count;
    bit exp_done;
    bit exp_busy;
    bit capture;
  } vec_t;

  vec_t tbl[$];
  logic [LFSR_W-1:0] step_exp [4];
  logic [SYM_W-1:0]  sa, sb;

  initial begin
    // Fill: N captures, one clearing press in DONE, one refill of slot 0.
    for (int i = 0; i < N_SCREENS; i++) begin
      tbl.push_back('{i + 1, (i == N_SCREENS - 1), (i != N_SCREENS - 1), 1'b1});
    end
    tbl.push_back('{0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1, 1'b0, 1'b1, 1'b1});
    step_exp[0] = LFSR_W'(8'h01);
    step_exp[1] = LFSR_W'(8'h02);
    step_exp[2] = LFSR_W'(8'h04);
    step_exp[3] = LFSR_W'(8'h08);

    rst    = 1'b0;
    button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_screens", 64'(screens), 64'd0);
    chk("rst_count",   64'(count),   64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_lfsr",    64'(dut.lfsr_s), 64'(step_exp[0]));

    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lfsr_step%0d", i), 64'(dut.lfsr_s), 64'(step_exp[i]));
    end
    @(posedge clk);
    #1;
    chk("lfsr_model", 64'(dut.lfsr_s), 64'(mdl));

    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].exp_count, tbl[i].exp_done, tbl[i].exp_busy, tbl[i].capture,
            1'b1, $sformatf("vec%0d", i));
`ifdef PSS_NO_REPEAT_EN
      if (i == N_SCREENS - 1) begin
        for (int j = 1; j < N_SCREENS; j++) begin
          sa = screens[(j-1)*SYM_W +: SYM_W];
          sb = screens[j*SYM_W +: SYM_W];
          chk($sformatf("norep_adj%0d", j), 64'(sa == sb), 64'd0);
        end
      end
`endif
    end

    // Second capture with the button left held, then reset mid-FILL.
    press(2, 1'b0, 1'b1, 1'b1, 1'b0, "hold2");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_screens", 64'(screens), 64'd0);
    chk("midrst_count",   64'(count),   64'd0);
    chk("midrst_done",    64'(done),    64'd0);
    chk("midrst_busy",    64'(busy),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("held_rst_nopress", 64'(count), 64'd0);
    @(negedge clk);
    button = 1'b0;
    repeat (3) @(posedge clk);

    // Long hold in IDLE yields exactly one capture.
    press(1, 1'b0, 1'b1, 1'b1, 1'b0, "long");
    repeat (60) @(posedge clk);
    #1;
    chk("long_hold_count", 64'(count), 64'd1);
    chk("long_hold_busy",  64'(busy),  64'd1);
    @(negedge clk);
    button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_lfsr", 64'(dut.lfsr_s), 64'(mdl));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
